// File: rtl/alarm_sequencer.sv
// alarm_sequencer: time-of-day counter, alarm setpoint and ring/snooze FSM.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_sequencer #(
  parameter int DAY_TICKS    = 1440,
  parameter int RING_TICKS   = 600,
  parameter int SNOOZE_TICKS = 300
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        tick,
  input  logic        set_time,
  input  logic [15:0] time_in,
  input  logic        set_alarm,
  input  logic [15:0] alarm_in,
  input  logic        arm,
  input  logic        disarm,
  input  logic        snooze,
  output logic [15:0] time_out,
  output logic [15:0] alarm_out,
  output logic        ring,
  output logic        armed,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    RINGING  = 2'b10,
    SNOOZING = 2'b11
  } state_e;

  localparam logic [15:0] DAY_MAX = 16'(DAY_TICKS - 1);
  localparam int RW = $clog2(RING_TICKS + 1);
  localparam logic [RW-1:0] RING_LD = RW'(RING_TICKS);

  state_e        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [15:0]   alarm_q, alarm_d;
  logic [15:0]   time_nx;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          ring_q, armed_q;
  logic          match;
  logic          snz_req;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  localparam logic [SW-1:0] SNZ_LD = SW'(SNOOZE_TICKS);
  logic [SW-1:0] scnt_q, scnt_d;
  assign snz_req = snooze;
`else
  localparam int unused_snz_ticks = SNOOZE_TICKS;
  logic unused_snz;
  assign unused_snz = snooze;
  assign snz_req = 1'b0;
`endif

  // Time and setpoint next-state; out-of-range loads leave registers alone.
  always_comb begin
    time_nx = (time_q == DAY_MAX) ? 16'd0 : time_q + 16'd1;
    time_d  = time_q;
    alarm_d = alarm_q;
    if (set_time) begin
      if (time_in <= DAY_MAX) time_d = time_in;
    end else if (tick) begin
      time_d = time_nx;
    end
    if (set_alarm && alarm_in <= DAY_MAX) alarm_d = alarm_in;
    match = tick & ~set_time & (time_nx == alarm_q);
  end

  // FSM next state and ring/snooze counter updates.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
`ifdef ALARM_SNOOZE_EN
    scnt_d  = scnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (disarm) begin
          state_d = IDLE;
        end else if (match) begin
          state_d = RINGING;
          rcnt_d  = RING_LD;
        end
      end
      RINGING: begin
        if (disarm) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (snz_req) begin
          state_d = SNOOZING;
          rcnt_d  = '0;
`ifdef ALARM_SNOOZE_EN
          scnt_d  = SNZ_LD;
`endif
        end else if (tick) begin
          rcnt_d = rcnt_q - RW'(1);
          if (rcnt_q == RW'(1)) state_d = ARMED;
        end
      end
      SNOOZING: begin
`ifdef ALARM_SNOOZE_EN
        if (disarm) begin
          state_d = IDLE;
          scnt_d  = '0;
        end else if (tick) begin
          scnt_d = scnt_q - SW'(1);
          if (scnt_q == SW'(1)) begin
            state_d = RINGING;
            rcnt_d  = RING_LD;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered output decodes.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= IDLE;
      time_q  <= '0;
      alarm_q <= '0;
      rcnt_q  <= '0;
      ring_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      alarm_q <= alarm_d;
      rcnt_q  <= rcnt_d;
      ring_q  <= (state_d == RINGING);
      armed_q <= (state_d != IDLE);
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze countdown register.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) scnt_q <= '0;
    else      scnt_q <= scnt_d;
  end
`endif

  assign time_out  = time_q;
  assign alarm_out = alarm_q;
  assign ring      = ring_q;
  assign armed     = armed_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed vector table plus multi-cycle sequences.
// Snooze checks follow ALARM_SNOOZE_EN, matching the DUT build.
module tb_alarm_sequencer;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        tick, set_time, set_alarm, arm, disarm, snooze;
  logic [15:0] time_in, alarm_in;
  logic [15:0] time_out, alarm_out;
  logic        ring, armed;
  logic [1:0]  state;

  int nvec = 0;
  int nmis = 0;

  alarm_sequencer #(
    .DAY_TICKS(1440), .RING_TICKS(10), .SNOOZE_TICKS(5)
  ) dut (
    .Clk(Clk), .Clr(Clr), .tick(tick), .set_time(set_time),
    .time_in(time_in), .set_alarm(set_alarm), .alarm_in(alarm_in),
    .arm(arm), .disarm(disarm), .snooze(snooze),
    .time_out(time_out), .alarm_out(alarm_out), .ring(ring),
    .armed(armed), .state(state)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        tk, st;
    logic [15:0] ti;
    logic        sa;
    logic [15:0] ai;
    logic        ar, da, sn;
    logic [15:0] et, ea;
    logic        er, earm;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    string n, logic tk, logic st, logic [15:0] ti, logic sa,
    logic [15:0] ai, logic ar, logic da, logic sn,
    logic [15:0] et, logic [15:0] ea, logic er, logic earm,
    logic [1:0] es);
    vec_t v;
    v.name = n; v.tk = tk; v.st = st; v.ti = ti; v.sa = sa;
    v.ai = ai; v.ar = ar; v.da = da; v.sn = sn;
    v.et = et; v.ea = ea; v.er = er; v.earm = earm; v.es = es;
    return v;
  endfunction

  function automatic vec_t tk1(string n, logic [15:0] et,
    logic er, logic [1:0] es);
    return mk(n, 1, 0, 0, 0, 0, 0, 0, 0, et, 16'd100, er,
              es != 2'b00, es);
  endfunction

  task automatic chk(string n, logic [15:0] et, logic [15:0] ea,
    logic er, logic earm, logic [1:0] es);
    nvec++;
    if ({time_out, alarm_out, ring, armed, state} !==
        {et, ea, er, earm, es}) begin
      nmis++;
      $display("FAIL %s: got t=%0d a=%0d ring=%0b armed=%0b st=%0d, want t=%0d a=%0d ring=%0b armed=%0b st=%0d",
        n, time_out, alarm_out, ring, armed, state,
        et, ea, er, earm, es);
    end
  endtask

  task automatic clr_in();
    tick = 0; set_time = 0; time_in = 0; set_alarm = 0;
    alarm_in = 0; arm = 0; disarm = 0; snooze = 0;
  endtask

  task automatic apply(vec_t v);
    @(negedge Clk);
    tick = v.tk; set_time = v.st; time_in = v.ti;
    set_alarm = v.sa; alarm_in = v.ai;
    arm = v.ar; disarm = v.da; snooze = v.sn;
    @(posedge Clk);
    #1;
    chk(v.name, v.et, v.ea, v.er, v.earm, v.es);
    clr_in();
  endtask

  initial begin
    clr_in();
    Clr = 1'b0;
    repeat (3) @(posedge Clk);
    #1 chk("reset", 16'd0, 16'd0, 0, 0, 2'd0);

    // Reset asserted mid-count clears the time counter at once.
    @(negedge Clk) Clr = 1'b1;
    apply(mk("st500", 0, 1, 16'd500, 0, 0, 0, 0, 0,
             16'd500, 0, 0, 0, 2'd0));
    apply(mk("tick501", 1, 0, 0, 0, 0, 0, 0, 0,
             16'd501, 0, 0, 0, 2'd0));
    #2 Clr = 1'b0;
    #1 chk("async_clr", 16'd0, 16'd0, 0, 0, 2'd0);
    @(negedge Clk) Clr = 1'b1;

    vecs.push_back(mk("st1439", 0, 1, 16'd1439, 0, 0, 0, 0, 0,
                      16'd1439, 0, 0, 0, 2'd0));
    vecs.push_back(mk("wrap", 1, 0, 0, 0, 0, 0, 0, 0,
                      16'd0, 0, 0, 0, 2'd0));
    vecs.push_back(mk("sa100", 0, 0, 0, 1, 16'd100, 0, 0, 0,
                      16'd0, 16'd100, 0, 0, 2'd0));
    vecs.push_back(mk("st98", 0, 1, 16'd98, 0, 0, 0, 0, 0,
                      16'd98, 16'd100, 0, 0, 2'd0));
    vecs.push_back(mk("arm", 0, 0, 0, 0, 0, 1, 0, 0,
                      16'd98, 16'd100, 0, 1, 2'd1));
    vecs.push_back(tk1("t99", 16'd99, 0, 2'd1));
    vecs.push_back(tk1("ring_on", 16'd100, 1, 2'd2));
    for (int i = 1; i <= 9; i++)
      vecs.push_back(tk1("ringing", 16'(100 + i), 1, 2'd2));
    vecs.push_back(tk1("autostop", 16'd110, 0, 2'd1));
    vecs.push_back(mk("sa1500", 0, 0, 0, 1, 16'd1500, 0, 0, 0,
                      16'd110, 16'd100, 0, 1, 2'd1));
    vecs.push_back(mk("st2000", 0, 1, 16'd2000, 0, 0, 0, 0, 0,
                      16'd110, 16'd100, 0, 1, 2'd1));
    vecs.push_back(mk("st99_tick", 1, 1, 16'd99, 0, 0, 0, 0, 0,
                      16'd99, 16'd100, 0, 1, 2'd1));
    vecs.push_back(tk1("rering", 16'd100, 1, 2'd2));
    vecs.push_back(mk("dis_snz", 0, 0, 0, 0, 0, 0, 1, 1,
                      16'd100, 16'd100, 0, 0, 2'd0));
    vecs.push_back(mk("dis_idle", 0, 0, 0, 0, 0, 0, 1, 0,
                      16'd100, 16'd100, 0, 0, 2'd0));
    vecs.push_back(mk("rearm", 0, 0, 0, 0, 0, 1, 0, 0,
                      16'd100, 16'd100, 0, 1, 2'd1));
    vecs.push_back(mk("arm_again", 0, 0, 0, 0, 0, 1, 0, 0,
                      16'd100, 16'd100, 0, 1, 2'd1));

    foreach (vecs[i]) apply(vecs[i]);

    // Enter ringing again from ARMED at t=100.
    apply(mk("st99", 0, 1, 16'd99, 0, 0, 0, 0, 0,
             16'd99, 16'd100, 0, 1, 2'd1));
    apply(tk1("ring2", 16'd100, 1, 2'd2));

`ifdef ALARM_SNOOZE_EN
    apply(mk("snooze", 0, 0, 0, 0, 0, 0, 0, 1,
             16'd100, 16'd100, 0, 1, 2'd3));
    apply(mk("snz_idle", 0, 0, 0, 0, 0, 0, 0, 0,
             16'd100, 16'd100, 0, 1, 2'd3));
    apply(tk1("snz1", 16'd101, 0, 2'd3));
    apply(tk1("snz2", 16'd102, 0, 2'd3));
    apply(mk("snz_again", 0, 0, 0, 0, 0, 0, 0, 1,
             16'd102, 16'd100, 0, 1, 2'd3));
    apply(tk1("snz3", 16'd103, 0, 2'd3));
    apply(tk1("snz4", 16'd104, 0, 2'd3));
    apply(tk1("snz_end", 16'd105, 1, 2'd2));
    for (int i = 1; i <= 9; i++)
      apply(tk1("reload", 16'(105 + i), 1, 2'd2));
    apply(mk("ring_idle", 0, 0, 0, 0, 0, 0, 0, 0,
             16'd114, 16'd100, 1, 1, 2'd2));
    apply(tk1("reload_end", 16'd115, 0, 2'd1));
`else
    apply(mk("snz_off", 0, 0, 0, 0, 0, 0, 0, 1,
             16'd100, 16'd100, 1, 1, 2'd2));
    for (int i = 1; i <= 9; i++)
      apply(tk1("snz_off_ring", 16'(100 + i), 1, 2'd2));
    apply(tk1("snz_off_stop", 16'd110, 0, 2'd1));
`endif

    // Reset while ringing clears everything asynchronously.
    apply(mk("st99b", 0, 1, 16'd99, 0, 0, 0, 0, 0,
             16'd99, 16'd100, 0, 1, 2'd1));
    apply(tk1("ring3", 16'd100, 1, 2'd2));
    #2 Clr = 1'b0;
    #1 chk("clr_ring", 16'd0, 16'd0, 0, 0, 2'd0);
    @(posedge Clk);
    #1 chk("clr_hold", 16'd0, 16'd0, 0, 0, 2'd0);
    @(negedge Clk) Clr = 1'b1;
    apply(mk("post_clr", 1, 0, 0, 0, 0, 0, 0, 1,
             16'd1, 16'd0, 0, 0, 2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
